uart_link: RTL and testbench

UART_LINK -- requirements
Module: uart_link

---
 rtl/uart_link.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_link.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_link.sv
// UART transceiver: independent TX and RX, each bit DIV clocks long, with a
// first-word-fall-through RX FIFO and sticky error flags.
`timescale 1ns/1ps
module uart_link #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  input  logic                          rxd,
  output logic [DATA_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic [2:0]                    err_flags,
  input  logic                          err_clr
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DATA_W);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic ODD = (PARITY == 2);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [AW:0]      FULL     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  tx_state_t          r_tx_state;
  logic [CNT_W-1:0]   r_tx_cnt;
  logic [IDX_W-1:0]   r_tx_idx;
  logic [DATA_W-1:0]  r_tx_shift;
  logic               r_tx_par;
  logic               r_txd;
  logic               r_tx_ready;

  rx_state_t          r_rx_state;
  logic [CNT_W-1:0]   r_rx_cnt;
  logic [IDX_W-1:0]   r_rx_idx;
  logic [DATA_W-1:0]  r_rx_shift;
  logic               r_rx_bad;
  logic               r_rx_s1, r_rx_s2, r_rx_prev;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [AW:0]        r_count;
  logic [2:0]         r_err;

  logic w_fall, w_bit_end, w_par_evt, w_frame_evt, w_push, w_pop, w_full, w_wr_en, w_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= ^tx_data ^ ODD;
            r_txd      <= 1'b0;
            r_tx_ready <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        TX_DATA: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == LAST_IDX) begin
              if (PARITY != 0) begin
                r_txd      <= r_tx_par;
                r_tx_state <= TX_PAR;
              end else begin
                r_txd      <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_idx   <= r_tx_idx + 1'b1;
              r_tx_shift <= r_tx_shift >> 1;
              r_txd      <= r_tx_shift[1];
            end
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        TX_PAR: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt   <= '0;
            r_txd      <= 1'b1;
            r_tx_state <= TX_STOP;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        TX_STOP: begin
          if (r_tx_cnt == BIT_END) begin
            r_tx_cnt   <= '0;
            r_tx_ready <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // Synchroniser resets low so a line already low at release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b0;
      r_rx_s2   <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  assign w_fall      = r_rx_prev & ~r_rx_s2;
  assign w_bit_end   = (r_rx_cnt == BIT_END);
  assign w_par_evt   = (r_rx_state == RX_PAR) && w_bit_end && ((^r_rx_shift ^ r_rx_s2) != ODD);
  assign w_frame_evt = (r_rx_state == RX_STOP) && w_bit_end && !r_rx_s2;
  assign w_push      = (r_rx_state == RX_STOP) && w_bit_end && r_rx_s2 && !r_rx_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_bad   <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_rx_cnt   <= '0;
            r_rx_bad   <= 1'b0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_END) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (w_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_W-1:1]};
            if (r_rx_idx == LAST_IDX) r_rx_state <= (PARITY != 0) ? RX_PAR : RX_STOP;
            else r_rx_idx <= r_rx_idx + 1'b1;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RX_PAR: begin
          if (w_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_bad   <= w_par_evt;
            r_rx_state <= RX_STOP;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RX_STOP: begin
          if (w_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_WAIT_IDLE;
          end else r_rx_cnt <= r_rx_cnt + 1'b1;
        end
        RX_WAIT_IDLE: if (r_rx_s2) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign w_pop   = rx_valid && rx_ready;
  assign w_full  = (r_count == FULL);
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_ovr   = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_err <= (err_clr ? 3'b000 : r_err) | {w_par_evt, w_frame_evt, w_ovr};
    end
  end

  assign tx_ready  = r_tx_ready;
  assign txd       = r_txd;
  assign rx_valid  = (r_count != '0);
  assign rx_data   = rx_valid ? r_mem[r_rd_ptr] : '0;
  assign rx_count  = r_count;
  assign err_flags = r_err;

endmodule

// File: tb/tb_uart_link.sv
// Bench for uart_link: dut0 (no parity, loopback) and dut1 (even parity, driven rxd),
// with scoreboard queues checked by per-DUT monitors on every FIFO pop.
`timescale 1ns/1ps
module tb_uart_link;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] tx_data0 = '0, rx_data0;
  logic       tx_valid0 = 1'b0, tx_ready0, txd0, rx_valid0, rx_ready0 = 1'b1, err_clr0 = 1'b0;
  logic [2:0] rx_count0, err_flags0;

  logic [7:0] tx_data1 = '0, rx_data1;
  logic       tx_valid1 = 1'b0, tx_ready1, txd1, rxd1 = 1'b1, rx_valid1, rx_ready1 = 1'b1, err_clr1 = 1'b0;
  logic [2:0] rx_count1, err_flags1;

  int nChecks = 0;
  int nErrors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  uart_link #(.CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .txd(txd0), .rxd(txd0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .rx_count(rx_count0), .err_flags(err_flags0), .err_clr(err_clr0));

  uart_link #(.CLK_HZ(1000000), .BAUD(100000), .DATA_W(8), .PARITY(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .txd(txd1), .rxd(rxd1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .rx_count(rx_count1), .err_flags(err_flags1), .err_clr(err_clr1));

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every pop the DUT performs must match the next queued word.
  always @(negedge clk) begin
    if (rst_n && rx_valid0 && rx_ready0) begin
      if (q0.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL rx0 unexpected word: got 0x%0h, expected none", rx_data0);
      end else checkOutput("rx0 data", {8'h00, rx_data0}, {8'h00, q0.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && rx_valid1 && rx_ready1) begin
      if (q1.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("[TB] FAIL rx1 unexpected word: got 0x%0h, expected none", rx_data1);
      end else checkOutput("rx1 data", {8'h00, rx_data1}, {8'h00, q1.pop_front()});
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input bit expectRx);
    int guard = 0;
    @(negedge clk);
    while (!tx_ready0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("tx_ready before send", {15'h0, tx_ready0}, 16'h1);
    tx_data0  = d;
    tx_valid0 = 1'b1;
    if (expectRx) q0.push_back(d);
    @(posedge clk);
    #1 tx_valid0 = 1'b0;
  endtask

  task automatic driveRxFrame(input logic [7:0] d, input logic p, input logic stopBit);
    logic [10:0] f;
    f = {stopBit, p, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      rxd1 = f[k];
      repeat (9) @(negedge clk);
    end
  endtask

  task automatic waitDrain(input int which);
    for (int i = 0; i < 400; i++) begin
      if ((which == 0 ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    if (which == 0) checkOutput("q0 drained", 16'(q0.size()), 16'h0);
    else            checkOutput("q1 drained", 16'(q1.size()), 16'h0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0] f;
    repeat (3) @(negedge clk);
    checkOutput("reset txd", {15'h0, txd0}, 16'h1);
    checkOutput("reset tx_ready", {15'h0, tx_ready0}, 16'h1);
    checkOutput("reset rx_valid", {15'h0, rx_valid0}, 16'h0);
    checkOutput("reset rx_count", {13'h0, rx_count0}, 16'h0);
    checkOutput("reset err_flags", {13'h0, err_flags0}, 16'h0);
    checkOutput("reset rx_data", {8'h0, rx_data0}, 16'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5 serial waveform, sampled mid-bit, with loopback receive
    f = {1'b1, 8'hA5, 1'b0};
    applyStimulus(8'hA5, 1'b1);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c % 10 == 5) begin
        checkOutput($sformatf("txd bit%0d", c / 10), {15'h0, txd0}, {15'h0, f[c / 10]});
        checkOutput("tx_ready busy", {15'h0, tx_ready0}, 16'h0);
      end
    end
    @(negedge clk);
    checkOutput("tx_ready after stop", {15'h0, tx_ready0}, 16'h1);
    waitDrain(0);

    // 0x3C loopback held in the FIFO, then popped
    @(posedge clk);
    #1 rx_ready0 = 1'b0;
    applyStimulus(8'h3C, 1'b1);
    for (int i = 0; i < 300 && !rx_valid0; i++) @(negedge clk);
    checkOutput("3C rx_valid", {15'h0, rx_valid0}, 16'h1);
    checkOutput("3C rx_count", {13'h0, rx_count0}, 16'h1);
    checkOutput("3C rx_data", {8'h0, rx_data0}, 16'h003C);
    @(posedge clk);
    #1 rx_ready0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("3C count after pop", {13'h0, rx_count0}, 16'h0);
    waitDrain(0);

    // Five words into a depth-4 FIFO: fifth is dropped with overrun
    @(posedge clk);
    #1 rx_ready0 = 1'b0;
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h44, 1'b1);
    applyStimulus(8'h55, 1'b0);
    repeat (150) @(negedge clk);
    checkOutput("full rx_count", {13'h0, rx_count0}, 16'h4);
    checkOutput("overrun flags", {13'h0, err_flags0}, 16'h1);
    @(posedge clk);
    #1 rx_ready0 = 1'b1;
    waitDrain(0);
    @(posedge clk);
    #1 err_clr0 = 1'b1;
    @(posedge clk);
    #1 err_clr0 = 1'b0;
    @(negedge clk);
    checkOutput("overrun cleared", {13'h0, err_flags0}, 16'h0);

    // Parity error on dut1: 0x01 needs even parity bit 1
    driveRxFrame(8'h01, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("parity_err set", {13'h0, err_flags1}, 16'h4);
    checkOutput("parity no push", {13'h0, rx_count1}, 16'h0);
    @(posedge clk);
    #1 err_clr1 = 1'b1;
    @(posedge clk);
    #1 err_clr1 = 1'b0;
    @(negedge clk);
    checkOutput("err_clr", {13'h0, err_flags1}, 16'h0);

    // Good parity frames
    q1.push_back(8'h01);
    driveRxFrame(8'h01, 1'b1, 1'b1);
    q1.push_back(8'hC3);
    driveRxFrame(8'hC3, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    waitDrain(1);
    checkOutput("good frames no error", {13'h0, err_flags1}, 16'h0);

    // Framing error: stop bit low and line held low 30 more cycles
    driveRxFrame(8'h5A, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    rxd1 = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("frame_err set", {13'h0, err_flags1}, 16'h2);
    checkOutput("frame no push", {13'h0, rx_count1}, 16'h0);
    q1.push_back(8'h96);
    driveRxFrame(8'h96, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    waitDrain(1);
    @(posedge clk);
    #1 err_clr1 = 1'b1;
    @(posedge clk);
    #1 err_clr1 = 1'b0;

    // Short glitch must not start a frame
    @(negedge clk);
    rxd1 = 1'b0;
    repeat (3) @(negedge clk);
    rxd1 = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("glitch no error", {13'h0, err_flags1}, 16'h0);
    checkOutput("glitch no push", {13'h0, rx_count1}, 16'h0);

    // Reset mid-frame aborts TX and the looped-back RX
    applyStimulus(8'h77, 1'b0);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midframe reset txd", {15'h0, txd0}, 16'h1);
    checkOutput("midframe reset tx_ready", {15'h0, tx_ready0}, 16'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    checkOutput("post reset rx_count", {13'h0, rx_count0}, 16'h0);
    checkOutput("post reset err_flags", {13'h0, err_flags0}, 16'h0);
    checkOutput("q0 empty at end", 16'(q0.size()), 16'h0);
    checkOutput("q1 empty at end", 16'(q1.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
